// File: rtl/uart_scan_rx_pkg.sv
// Shared definitions for the scan-enabled UART receiver: state codes,
// oversampling constants and the baud divider calculation.
package uart_scan_rx_pkg;

  localparam int OVERSAMPLE_C  = 16;
  localparam int TICK_MID_C    = 7;   // middle of the start bit
  localparam int TICK_LAST_C   = 15;  // middle of a data/stop bit, counted from start-bit centre

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
  } rx_state_e;

  // Clocks per oversample tick, integer-truncated.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_scan_rx_if.sv
// Receiver-side bus: serial line in, received byte and status out.
// Handshake: done is a one-cycle strobe qualifying data_out; there is no
// ready/back-pressure, the consumer must take data_out in the cycle done is high.
// frame_err is a one-cycle strobe for a bad stop bit and never coincides with done.
interface uart_scan_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       done;
  logic       frame_err;
  logic       busy;
  logic [2:0] state;

  modport master (
    input  rx,
    output data_out, done, frame_err, busy, state
  );

  modport slave (
    output rx,
    input  data_out, done, frame_err, busy, state
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV enabled clocks.
// restart forces the phase back to zero so sampling aligns to the start edge.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // Free-running divider counter, held when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_scan_rx.sv
// 8N1 UART receiver, 16x oversampled, with a mux-D scan chain running
// scan_in -> shift_reg[7..0] -> data_out[7..0] -> scan_out.
module uart_scan_rx
  import uart_scan_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = OVERSAMPLE_C
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_scan_rx_if.master        bus,
  input  logic                  scan_enable,
  input  logic                  scan_in,
  output logic                  scan_out
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);

  rx_state_e  state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       wait_high_q, wait_high_d;
  logic       rx_meta, rx_s;
  logic       tick, tick_en, restart;
  logic       shift_bit, capture, frame_bad;
  logic [7:0] shift_reg, data_q;
  logic       done_q, ferr_q;

  assign tick_en = !scan_enable;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .en      (tick_en),
    .tick    (tick)
  );

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state and counters register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      wait_high_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      wait_high_q <= wait_high_d;
    end
  end

  // Next-state and datapath strobes; everything holds while scanning.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    wait_high_d = wait_high_q;
    restart     = 1'b0;
    shift_bit   = 1'b0;
    capture     = 1'b0;
    frame_bad   = 1'b0;
    if (!scan_enable) begin
      unique case (state_q)
        ST_IDLE: begin
          // After a frame error the line must go high before re-arming,
          // so a held break reports only once.
          if (wait_high_q) begin
            if (rx_s) wait_high_d = 1'b0;
          end else if (!rx_s) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
            restart    = 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tick_cnt_q == 4'(TICK_MID_C)) begin
              tick_cnt_d = '0;
              if (rx_s) begin
                state_d = ST_IDLE;
              end else begin
                state_d   = ST_DATA;
                bit_cnt_d = '0;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            if (tick_cnt_q == 4'(TICK_LAST_C)) begin
              shift_bit = 1'b1;
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_d = ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            if (tick_cnt_q == 4'(TICK_LAST_C)) begin
              state_d = ST_IDLE;
              if (rx_s) begin
                capture = 1'b1;
              end else begin
                frame_bad   = 1'b1;
                wait_high_d = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Shift/data registers with scan mux, and registered status strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else if (scan_enable) begin
      shift_reg <= {scan_in, shift_reg[7:1]};
      data_q    <= {shift_reg[0], data_q[7:1]};
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      done_q <= capture;
      ferr_q <= frame_bad;
      if (shift_bit) shift_reg <= {rx_s, shift_reg[7:1]};
      if (capture)   data_q    <= shift_reg;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.done      = done_q && !scan_enable;
  assign bus.frame_err = ferr_q && !scan_enable;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.state     = state_q;
  assign scan_out      = data_q[0];

endmodule
